// File: rtl/my_dmux_sched.sv
// 1-to-2 word demultiplexer sequencer: steers a valid/ready input stream to
// channel A or B, either by per-word select or by a round-robin burst scheduler.
module my_dmux_sched #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             rr_ptr,
  output logic [15:0]      count_a,
  output logic [15:0]      count_b
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_state_e;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  rr_state_e        rr_state_q, rr_state_d;
  logic [7:0]       burst_q, burst_d;
  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [15:0]      count_a_q, count_a_d;
  logic [15:0]      count_b_q, count_b_d;

  logic tgt;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic acc_a;
  logic acc_b;

  // Target selection and handshake; in_ready never looks at in_valid.
  always_comb begin
    tgt       = mode ? rr_state_q : in_sel;
    tgt_valid = tgt ? b_valid_q : a_valid_q;
    tgt_ready = tgt ? b_ready   : a_ready;
    in_ready  = ~tgt_valid | tgt_ready;
    accept    = in_valid & in_ready;
    acc_a     = accept & ~tgt;
    acc_b     = accept &  tgt;
  end

  // Output registers: a load wins over a drain so a full channel sustains one word per cycle.
  always_comb begin
    a_valid_d = acc_a | (a_valid_q & ~a_ready);
    b_valid_d = acc_b | (b_valid_q & ~b_ready);
    a_data_d  = acc_a ? in_data : a_data_q;
    b_data_d  = acc_b ? in_data : b_data_q;
    count_a_d = count_a_q + 16'(acc_a);
    count_b_d = count_b_q + 16'(acc_b);
  end

  // Round-robin scheduler; directed mode parks it at A with a fresh burst.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rr_state_d = rr_state_q;
    burst_d    = burst_q;
    if (!mode) begin
      rr_state_d = PTR_A;
      burst_d    = '0;
    end else if (accept) begin
      if (burst_q == BURST_LAST) begin
        burst_d    = '0;
        rr_state_d = (rr_state_q == PTR_A) ? PTR_B : PTR_A;
      end else begin
        burst_d = burst_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      // NOTE: the data registers are reset too, since their value after reset is observable.
      rr_state_q <= PTR_A;
      burst_q    <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      rr_state_q <= rr_state_d;
      burst_q    <= burst_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
    end
  end

  assign a_data  = a_data_q;
  assign a_valid = a_valid_q;
  assign b_data  = b_data_q;
  assign b_valid = b_valid_q;
  assign rr_ptr  = rr_state_q;
  assign count_a = count_a_q;
  assign count_b = count_b_q;

endmodule

// File: tb/tb_my_dmux_sched.sv
// Table-driven bench for my_dmux_sched: directed, backpressure, round-robin and
// stall vectors, followed by hand-written counter-wrap and mid-operation reset sequences.
module tb_my_dmux_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        rr_ptr;
  logic [15:0] count_a;
  logic [15:0] count_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  my_dmux_sched #(.WIDTH(16), .BURST(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .rr_ptr   (rr_ptr),
    .count_a  (count_a),
    .count_b  (count_b)
  );

  typedef struct {
    logic        mode;
    logic [15:0] din;
    logic        sel;
    logic        vld;
    logic        ar;
    logic        br;
    logic        exp_ir;
    logic        exp_av;
    logic [15:0] exp_ad;
    logic        exp_bv;
    logic [15:0] exp_bd;
    logic        exp_rr;
    logic [15:0] exp_ca;
    logic [15:0] exp_cb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] outs();
    return {61'd0, a_valid, a_data, b_valid, b_data, rr_ptr, count_a, count_b};
  endfunction

  function automatic logic [127:0] pack_exp(input vec_t v);
    return {61'd0, v.exp_av, v.exp_ad, v.exp_bv, v.exp_bd, v.exp_rr, v.exp_ca, v.exp_cb};
  endfunction

  initial begin
    // mode, din, sel, vld, ar, br | in_ready | a_valid, a_data, b_valid, b_data, rr_ptr, count_a, count_b
    // Directed, both consumers ready.
    vecs.push_back('{1'b0, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'd1, 16'd0});
    vecs.push_back('{1'b0, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 16'h0002, 1'b0, 16'd1, 16'd1});
    vecs.push_back('{1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 16'h0003, 1'b0, 16'd1, 16'd2});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h0003, 1'b0, 16'd1, 16'd2});
    // Backpressure on B; A still accepts while B stalls.
    vecs.push_back('{1'b0, 16'h00AA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 16'h00AA, 1'b0, 16'd1, 16'd3});
    vecs.push_back('{1'b0, 16'h00BB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h00AA, 1'b0, 16'd1, 16'd3});
    vecs.push_back('{1'b0, 16'h00CC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00CC, 1'b1, 16'h00AA, 1'b0, 16'd2, 16'd3});
    vecs.push_back('{1'b0, 16'h00BB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00CC, 1'b1, 16'h00BB, 1'b0, 16'd2, 16'd4});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00CC, 1'b0, 16'h00BB, 1'b0, 16'd2, 16'd4});
    // Round-robin, BURST=4, ten words; in_sel held at 0 and ignored.
    vecs.push_back('{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h00BB, 1'b0, 16'd3, 16'd4});
    vecs.push_back('{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 16'h00BB, 1'b0, 16'd4, 16'd4});
    vecs.push_back('{1'b1, 16'h0012, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0012, 1'b0, 16'h00BB, 1'b0, 16'd5, 16'd4});
    vecs.push_back('{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0013, 1'b0, 16'h00BB, 1'b1, 16'd6, 16'd4});
    vecs.push_back('{1'b1, 16'h0014, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b1, 16'h0014, 1'b1, 16'd6, 16'd5});
    vecs.push_back('{1'b1, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b1, 16'h0015, 1'b1, 16'd6, 16'd6});
    vecs.push_back('{1'b1, 16'h0016, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b1, 16'h0016, 1'b1, 16'd6, 16'd7});
    vecs.push_back('{1'b1, 16'h0017, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b1, 16'h0017, 1'b0, 16'd6, 16'd8});
    vecs.push_back('{1'b1, 16'h0018, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0018, 1'b0, 16'h0017, 1'b0, 16'd7, 16'd8});
    vecs.push_back('{1'b1, 16'h0019, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0019, 1'b0, 16'h0017, 1'b0, 16'd8, 16'd8});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0019, 1'b0, 16'h0017, 1'b0, 16'd8, 16'd8});
    // Round-robin stall on A after two words, then mode 0 -> 1 restarts a fresh burst at A.
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0019, 1'b0, 16'h0017, 1'b0, 16'd8, 16'd8});
    vecs.push_back('{1'b1, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h0017, 1'b0, 16'd9, 16'd8});
    vecs.push_back('{1'b1, 16'h0021, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0021, 1'b0, 16'h0017, 1'b0, 16'd10, 16'd8});
    vecs.push_back('{1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0021, 1'b0, 16'h0017, 1'b0, 16'd10, 16'd8});
    vecs.push_back('{1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0021, 1'b0, 16'h0017, 1'b0, 16'd10, 16'd8});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0021, 1'b0, 16'h0017, 1'b0, 16'd10, 16'd8});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0021, 1'b0, 16'h0017, 1'b0, 16'd10, 16'd8});
    vecs.push_back('{1'b1, 16'h0030, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0030, 1'b0, 16'h0017, 1'b0, 16'd11, 16'd8});
    vecs.push_back('{1'b1, 16'h0031, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0031, 1'b0, 16'h0017, 1'b0, 16'd12, 16'd8});
    vecs.push_back('{1'b1, 16'h0032, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0032, 1'b0, 16'h0017, 1'b0, 16'd13, 16'd8});
    vecs.push_back('{1'b1, 16'h0033, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0033, 1'b0, 16'h0017, 1'b1, 16'd14, 16'd8});
    vecs.push_back('{1'b1, 16'h0034, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0033, 1'b1, 16'h0034, 1'b1, 16'd14, 16'd9});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0033, 1'b0, 16'h0034, 1'b1, 16'd14, 16'd9});

    reset_n  = 1'b0;
    mode     = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;

    // Reset for two cycles, then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_outputs", outs(), 128'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      mode     = vecs[i].mode;
      in_data  = vecs[i].din;
      in_sel   = vecs[i].sel;
      in_valid = vecs[i].vld;
      a_ready  = vecs[i].ar;
      b_ready  = vecs[i].br;
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_outputs", i), outs(), pack_exp(vecs[i]));
    end

    // Counter wrap: clear, stream 65535 words to A, then one more.
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    mode     = 1'b0;
    in_sel   = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      if (i != 0) @(negedge clk);
      in_data = 16'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("count_a_ffff", 128'(count_a), 128'hFFFF);
    check("a_data_last_stream", 128'(a_data), 128'hFFFE);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    a_ready  = 1'b0;
    #1;
    check("count_a_wrap", 128'(count_a), 128'h0000);
    check("a_hold_before_reset", 128'({a_valid, a_data}), 128'({1'b1, 16'h5555}));
    check("in_ready_stalled", 128'(in_ready), 128'd0);

    // Reset while A holds an undrained word.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midop_reset_outputs", outs(), 128'd0);
    check("midop_reset_in_ready", 128'(in_ready), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
